// File: rtl/exe_alu_stage.sv
// Execute-stage ALU: computes the data-processing/address result from
// val1 (Rn) and the generated val2, keeps the NZCV status register, and
// registers the result with its destination and controls for EXE/MEM.
module exe_alu_stage #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              s_bit,
  input  logic [WIDTH-1:0]  val1,
  input  logic [WIDTH-1:0]  val2,
  input  logic [DEST_W-1:0] dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  output logic              out_valid,
  output logic [WIDTH-1:0]  alu_res,
  output logic [DEST_W-1:0] dest_q,
  output logic              wb_en_q,
  output logic              mem_r_en_q,
  output logic              mem_w_en_q,
  output logic [3:0]        status
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam int MSB = WIDTH - 1;

  logic              outValid_q;
  logic [WIDTH-1:0]  aluRes_q;
  logic [WIDTH-1:0]  aluRes_d;
  logic [DEST_W-1:0] destReg_q;
  logic              wbEn_q;
  logic              memREn_q;
  logic              memWEn_q;
  logic [3:0]        status_q;
  logic [3:0]        status_d;

  logic [WIDTH-1:0]  opB;
  logic              carryIn;
  logic              isArith;
  logic              isSub;
  logic              isLogic;
  logic [WIDTH:0]    sum;
  logic              carryFlag;
  logic              resultNeg;
  logic              resultZero;
  logic              overflow;
  logic [3:0]        flagsNext;
  logic              statusWrite;

  // Operand conditioning: subtraction is done as val1 + ~val2 + carry-in,
  // and ADC/SBC take their carry-in from the flags as they stand now.
  always_comb begin
    opB     = val2;
    carryIn = 1'b0;
    isArith = 1'b0;
    isSub   = 1'b0;
    isLogic = 1'b0;
    case (exe_cmd)
      CMD_ADD: isArith = 1'b1;
      CMD_ADC: begin
        isArith = 1'b1;
        carryIn = status_q[1];
      end
      CMD_SUB: begin
        isArith = 1'b1;
        isSub   = 1'b1;
        opB     = ~val2;
        carryIn = 1'b1;
      end
      CMD_SBC: begin
        isArith = 1'b1;
        isSub   = 1'b1;
        opB     = ~val2;
        carryIn = status_q[1];
      end
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: isLogic = 1'b1;
      default: ;
    endcase
  end

  assign sum       = {1'b0, val1} + {1'b0, opB} + {{WIDTH{1'b0}}, carryIn};
  assign carryFlag = sum[WIDTH];

  // Result select; unknown opcodes produce zero and leave the flags alone.
  always_comb begin
    aluRes_d = '0;
    case (exe_cmd)
      CMD_MOV: aluRes_d = val2;
      CMD_MVN: aluRes_d = ~val2;
      CMD_AND: aluRes_d = val1 & val2;
      CMD_ORR: aluRes_d = val1 | val2;
      CMD_EOR: aluRes_d = val1 ^ val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: aluRes_d = sum[MSB:0];
      default: aluRes_d = '0;
    endcase
  end

  // Flag generation and the status write enable.
  always_comb begin
    resultNeg  = aluRes_d[MSB];
    resultZero = (aluRes_d == '0);
    if (isSub) begin
      overflow = (val1[MSB] != val2[MSB]) && (aluRes_d[MSB] != val1[MSB]);
    end else begin
      overflow = (val1[MSB] == val2[MSB]) && (aluRes_d[MSB] != val1[MSB]);
    end
    if (isArith) begin
      flagsNext = {resultNeg, resultZero, carryFlag, overflow};
    end else begin
      flagsNext = {resultNeg, resultZero, status_q[1:0]};
    end
    statusWrite = in_valid && s_bit && !stall && !flush && (isArith || isLogic);
    status_d    = statusWrite ? flagsNext : status_q;
  end

  // Pipeline register: reset clears, stall freezes, flush squashes the
  // valid/control bits but keeps the flags, otherwise load the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      aluRes_q   <= '0;
      destReg_q  <= '0;
      wbEn_q     <= 1'b0;
      memREn_q   <= 1'b0;
      memWEn_q   <= 1'b0;
      status_q   <= 4'b0000;
    end else if (stall) begin
      outValid_q <= outValid_q;
      aluRes_q   <= aluRes_q;
      destReg_q  <= destReg_q;
      wbEn_q     <= wbEn_q;
      memREn_q   <= memREn_q;
      memWEn_q   <= memWEn_q;
      status_q   <= status_q;
    end else if (flush) begin
      outValid_q <= 1'b0;
      wbEn_q     <= 1'b0;
      memREn_q   <= 1'b0;
      memWEn_q   <= 1'b0;
      status_q   <= status_q;
    end else begin
      outValid_q <= in_valid;
      aluRes_q   <= aluRes_d;
      destReg_q  <= dest;
      wbEn_q     <= wb_en && in_valid;
      memREn_q   <= mem_r_en && in_valid;
      memWEn_q   <= mem_w_en && in_valid;
      status_q   <= status_d;
    end
  end

  assign out_valid  = outValid_q;
  assign alu_res    = aluRes_q;
  assign dest_q     = destReg_q;
  assign wb_en_q    = wbEn_q;
  assign mem_r_en_q = memREn_q;
  assign mem_w_en_q = memWEn_q;
  assign status     = status_q;

endmodule
